// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl: arbitrates write requesters onto a bank of transparent latches.
// Each write runs SETUP (data only), OPEN (one enable for OPEN_CYC cycles) and CLOSE (hold).
// Macro LATCH_BANK_CTRL_RR_EN selects round-robin arbitration; otherwise fixed priority.
module latch_bank_ctrl #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned OPEN_CYC    = 1,
    localparam int unsigned ADDR_W     = $clog2(NUM_ENTRIES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_ENTRIES-1:0]    lat_en,
    output logic [DATA_W-1:0]         lat_d,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        CLOSE = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cap_addr;
    logic [CNT_W-1:0]    cnt;

    logic [NUM_REQ-1:0]  gnt_c;
    logic                gnt_any_c;
    logic [ADDR_W-1:0]   gnt_addr_c;
    logic [DATA_W-1:0]   gnt_data_c;

`ifdef LATCH_BANK_CTRL_RR_EN
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    gnt_idx_c;

    // Round-robin pick: scan from rr_ptr upward, wrapping at NUM_REQ
    always_comb begin
        gnt_c      = '0;
        gnt_any_c  = 1'b0;
        gnt_addr_c = '0;
        gnt_data_c = '0;
        gnt_idx_c  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            int unsigned idx;
            idx = (32'(rr_ptr) + i) % NUM_REQ;
            if (!gnt_any_c && req_valid[idx]) begin
                gnt_any_c  = 1'b1;
                gnt_c[idx] = 1'b1;
                gnt_idx_c  = IDX_W'(idx);
                gnt_addr_c = req_addr[idx*ADDR_W +: ADDR_W];
                gnt_data_c = req_data[idx*DATA_W +: DATA_W];
            end
        end
    end
`else
    // Fixed-priority pick: lowest-index valid requester wins
    always_comb begin
        gnt_c      = '0;
        gnt_any_c  = 1'b0;
        gnt_addr_c = '0;
        gnt_data_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any_c && req_valid[i]) begin
                gnt_any_c  = 1'b1;
                gnt_c[i]   = 1'b1;
                gnt_addr_c = req_addr[i*ADDR_W +: ADDR_W];
                gnt_data_c = req_data[i*DATA_W +: DATA_W];
            end
        end
    end
`endif

    // Accept strobe is only offered while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE) begin
            req_ready = gnt_c;
        end
    end

    // Write sequencer: capture, data setup, enable window, hold/close
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cap_addr <= '0;
            cnt      <= '0;
            lat_en   <= '0;
            lat_d    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef LATCH_BANK_CTRL_RR_EN
            rr_ptr   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (gnt_any_c) begin
                        cap_addr <= gnt_addr_c;
                        lat_d    <= gnt_data_c;
                        busy     <= 1'b1;
                        state    <= SETUP;
`ifdef LATCH_BANK_CTRL_RR_EN
                        rr_ptr   <= IDX_W'((32'(gnt_idx_c) + 32'd1) % NUM_REQ);
`endif
                    end
                end
                SETUP: begin
                    lat_en <= NUM_ENTRIES'(1) << cap_addr;
                    cnt    <= CNT_W'(OPEN_CYC - 1);
                    state  <= OPEN;
                end
                OPEN: begin
                    if (cnt == '0) begin
                        lat_en <= '0;
                        done   <= 1'b1;
                        state  <= CLOSE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                CLOSE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    lat_en <= '0;
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Bench for latch_bank_ctrl: scoreboard on the default (OPEN_CYC=1) instance,
// directed checks on a second instance built with OPEN_CYC=3.
module tb_latch_bank_ctrl;

    localparam int unsigned NR = 4;
    localparam int unsigned NE = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned DW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [NE-1:0]     lat_en;
    logic [DW-1:0]     lat_d;
    logic              busy;
    logic              done;

    logic              b_rst;
    logic [NR-1:0]     b_req_valid;
    logic [NR*AW-1:0]  b_req_addr;
    logic [NR*DW-1:0]  b_req_data;
    logic [NR-1:0]     b_req_ready;
    logic [NE-1:0]     b_lat_en;
    logic [DW-1:0]     b_lat_d;
    logic              b_busy;
    logic              b_done;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;

    typedef struct {
        logic [NE-1:0] en;
        logic [DW-1:0] d;
    } txn_t;

    logic [NR-1:0] exp_gnt[$];
    txn_t          exp_txn[$];

    latch_bank_ctrl #(.NUM_REQ(NR), .NUM_ENTRIES(NE), .DATA_W(DW), .OPEN_CYC(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .lat_en(lat_en),
        .lat_d(lat_d), .busy(busy), .done(done)
    );

    latch_bank_ctrl #(.NUM_REQ(NR), .NUM_ENTRIES(NE), .DATA_W(DW), .OPEN_CYC(3)) dut3 (
        .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_addr(b_req_addr),
        .req_data(b_req_data), .req_ready(b_req_ready), .lat_en(b_lat_en),
        .lat_d(b_lat_d), .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // Waits (bounded) for an accept on any requester in mask; returns its cycle
    task automatic wait_ready(input logic [NR-1:0] mask, output int unsigned at);
        bit found;
        found = 1'b0;
        at    = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if ((req_ready & mask) != '0) begin
                found = 1'b1;
                at    = cyc;
            end
        end
        if (!found) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Single request from one requester, run to completion
    task automatic single(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int unsigned n;
        logic [NR-1:0] m;
        logic [NE-1:0] e;
        m = '0;
        m[i] = 1'b1;
        e = NE'(1) << a;
        set_req(i, a, d);
        exp_gnt.push_back(m);
        exp_txn.push_back('{en: e, d: d});
        @(posedge clk); #1;
        req_valid = m;
        wait_ready(m, n);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(negedge clk);
    endtask

    // Scoreboard monitor and invariants for the OPEN_CYC=1 instance
    logic [NE-1:0] prev_en  = '0;
    logic [DW-1:0] prev_d   = '0;
    bit            prev_rst = 1'b1;
    bit            pending  = 1'b0;
    int unsigned   acc_cyc  = 0;

    always @(negedge clk) begin
        txn_t t;
        logic [NR-1:0] g;
        check("inv_onehot0", 32'($onehot0(lat_en)), 32'd1);
        if ((prev_en != '0 || lat_en != '0) && !prev_rst)
            check("inv_lat_d_stable", 32'(lat_d), 32'(prev_d));
        if (rst) check("ready_during_rst", 32'(req_ready), 32'd0);
        if (req_ready != '0) begin
            if (exp_gnt.size() == 0) begin
                check("unexpected_grant", 32'(req_ready), 32'd0);
            end else begin
                g = exp_gnt.pop_front();
                check("grant", 32'(req_ready), 32'(g));
            end
            acc_cyc = cyc;
            pending = 1'b1;
        end
        if (lat_en != '0 && prev_en == '0) begin
            if (exp_txn.size() == 0) begin
                check("unexpected_enable", 32'(lat_en), 32'd0);
            end else begin
                t = exp_txn.pop_front();
                check("enable_value", 32'(lat_en), 32'(t.en));
                check("enable_data", 32'(lat_d), 32'(t.d));
                check("enable_latency", cyc - acc_cyc, 32'd2);
            end
        end
        if (done) begin
            check("done_pending", 32'(pending), 32'd1);
            check("done_latency", cyc - acc_cyc, 32'd3);
            pending = 1'b0;
        end
        if (rst) pending = 1'b0;
        prev_en  = lat_en;
        prev_d   = lat_d;
        prev_rst = rst;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        int unsigned t[5];
        int unsigned k;
        bit found;

        rst         = 1'b1;
        req_valid   = '1;
        req_addr    = '0;
        req_data    = '0;
        b_rst       = 1'b1;
        b_req_valid = '0;
        b_req_addr  = '0;
        b_req_data  = '0;

        // Reset state, with requests pending that must not be accepted
        repeat (3) begin
            @(negedge clk);
            check("rst_lat_en", 32'(lat_en), 32'd0);
            check("rst_lat_d", 32'(lat_d), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        rst       = 1'b0;
        b_rst     = 1'b0;

        // Single write: requester 0, addr 5, data 0xA5
        set_req(0, 3'd5, 8'hA5);
        exp_gnt.push_back(4'b0001);
        exp_txn.push_back('{en: 8'h20, d: 8'hA5});
        @(posedge clk); #1;
        req_valid = 4'b0001;
        wait_ready(4'b0001, n);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("w1_setup_lat_d", 32'(lat_d), 32'hA5);
        check("w1_setup_lat_en", 32'(lat_en), 32'd0);
        check("w1_setup_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("w1_open_lat_en", 32'(lat_en), 32'h20);
        @(negedge clk);
        check("w1_close_done", 32'(done), 32'd1);
        check("w1_close_lat_en", 32'(lat_en), 32'd0);
        check("w1_close_lat_d", 32'(lat_d), 32'hA5);
        @(negedge clk);
        check("w1_idle_busy", 32'(busy), 32'd0);
        check("w1_idle_done", 32'(done), 32'd0);

        // Collision from a fresh reset: all four requesters held valid
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, AW'(2 * i), DW'(8'h10 + i));
        for (int g = 0; g < 5; g++) begin
`ifdef LATCH_BANK_CTRL_RR_EN
            k = g % 4;
`else
            k = 0;
`endif
            exp_gnt.push_back(NR'(1) << k);
            exp_txn.push_back('{en: NE'(1) << (2 * k), d: DW'(8'h10 + k)});
        end
        @(posedge clk); #1;
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_ready(4'b1111, t[g]);
            if (g > 0) check("grant_spacing", t[g] - t[g-1], 32'd4);
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (5) @(negedge clk);

        // Reset during the first OPEN cycle discards the write
        set_req(2, 3'd3, 8'h3C);
        exp_gnt.push_back(4'b0100);
        exp_txn.push_back('{en: 8'h08, d: 8'h3C});
        @(posedge clk); #1;
        req_valid = 4'b0100;
        wait_ready(4'b0100, n);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_open_lat_en", 32'(lat_en), 32'h08);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_lat_en", 32'(lat_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        // Pointer is back at 0: requester 0 wins the next collision
        set_req(0, 3'd2, 8'h42);
        exp_gnt.push_back(4'b0001);
        exp_txn.push_back('{en: 8'h04, d: 8'h42});
        @(posedge clk); #1;
        req_valid = 4'b1111;
        wait_ready(4'b1111, n);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (5) @(negedge clk);

        // Valid withdrawn after one cycle still completes the write
        set_req(1, 3'd1, 8'h5A);
        exp_gnt.push_back(4'b0010);
        exp_txn.push_back('{en: 8'h02, d: 8'h5A});
        @(posedge clk); #1;
        req_valid = 4'b0010;
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("withdrawn_lat_en", 32'(lat_en), 32'h02);
        check("withdrawn_lat_d", 32'(lat_d), 32'h5A);
        repeat (3) @(negedge clk);

        // Address and data boundaries
        single(3, 3'd7, 8'hFF);
        single(3, 3'd0, 8'h00);

        // OPEN_CYC=3 instance: addr 7 enabled for exactly three cycles
        b_req_addr[2:0] = 3'd7;
        b_req_data[7:0] = 8'h81;
        @(posedge clk); #1;
        b_req_valid = 4'b0001;
        found = 1'b0;
        for (int j = 0; j < 40 && !found; j++) begin
            @(negedge clk);
            if (b_req_ready != '0) found = 1'b1;
        end
        check("oc3_ready", 32'(b_req_ready), 32'd1);
        @(posedge clk); #1;
        b_req_valid = '0;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            check("oc3_lat_en", 32'(b_lat_en), (j >= 2 && j <= 4) ? 32'h80 : 32'd0);
            if (j <= 5) check("oc3_lat_d", 32'(b_lat_d), 32'h81);
            check("oc3_done", 32'(b_done), (j == 5) ? 32'd1 : 32'd0);
            check("oc3_busy", 32'(b_busy), (j <= 5) ? 32'd1 : 32'd0);
        end

        repeat (3) @(negedge clk);
        check("gnt_queue_drained", exp_gnt.size(), 32'd0);
        check("txn_queue_drained", exp_txn.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
